// File: rtl/mul32_seq_ctrl.sv
// mul32_seq_ctrl: 32x32 unsigned multiply by time-sharing one external 8x8 core over 16 steps.
// Latency: 17 cycles from acceptance to out_valid (1 cycle for the zero-operand bypass).
// Backpressure: in_ready is low while busy; the product is held in DONE until out_ready.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     operand handshake carrying op_a, op_b (32-bit unsigned)
//   out_valid/out_ready   result handshake carrying product (64-bit unsigned)
//   busy                  high in CALC or DONE
//   mul_a, mul_b, mul_p   byte operands to, and 16-bit product from, the external 8x8 core
module mul32_seq_ctrl #(
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] product,
  output logic        busy,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_p
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [3:0]  k;
  logic [63:0] acc;
  logic        out_valid_reg;

  logic        accept;
  logic        zero_op;
  logic [2:0]  byte_pos;
  logic [63:0] pp_shifted;

  assign accept  = (state == IDLE) && in_valid;
  assign zero_op = (op_a == 32'd0) || (op_b == 32'd0);

  // Byte i of A times byte j of B lands at bit offset 8*(i+j); i+j never exceeds 6.
  assign byte_pos   = {1'b0, k[1:0]} + {1'b0, k[3:2]};
  assign pp_shifted = {48'h0, mul_p} << {byte_pos, 3'b000};

  // Next-state and decoded outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    mul_a     = 8'h00;
    mul_b     = 8'h00;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (EARLY_ZERO && zero_op) begin
            state_nxt = DONE;
          end else begin
            state_nxt = CALC;
          end
        end
      end
      CALC: begin
        busy  = 1'b1;
        // Only drive the core here so it sees no toggling while idle.
        mul_a = a_reg[8*k[1:0] +: 8];
        mul_b = b_reg[8*k[3:2] +: 8];
        if (k == 4'd15) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      a_reg         <= 32'd0;
      b_reg         <= 32'd0;
      k             <= 4'd0;
      acc           <= 64'd0;
      out_valid_reg <= 1'b0;
    end else begin
      state         <= state_nxt;
      // Registered so it rises in the first DONE cycle and drops on the handshake edge.
      out_valid_reg <= (state_nxt == DONE);
      if (accept) begin
        a_reg <= op_a;
        b_reg <= op_b;
        acc   <= 64'd0;
        k     <= 4'd0;
      end else if (state == CALC) begin
        acc <= acc + pp_shifted;
        // Wraps to 0 after step 15, ready for the next operation.
        k   <= k + 4'd1;
      end
    end
  end

  // acc is frozen outside CALC, so the product is stable throughout DONE.
  assign product   = acc;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// tb_mul32_seq_ctrl: randomized self-checking bench for mul32_seq_ctrl against an arithmetic model.
// Main instance uses the zero bypass; a second instance checks the non-bypass zero path.
// Expected product is a plain 64-bit multiply; expected latency and core byte schedule come from the step rules.
module tb_mul32_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic        busy;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_p;

  logic        in_valid2;
  logic        in_ready2;
  logic        out_valid2;
  logic        out_ready2;
  logic [63:0] product2;
  logic        busy2;
  logic [7:0]  mul_a2;
  logic [7:0]  mul_b2;
  logic [15:0] mul_p2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // External 8x8 combinational cores.
  assign mul_p  = 16'(mul_a) * 16'(mul_b);
  assign mul_p2 = 16'(mul_a2) * 16'(mul_b2);

  mul32_seq_ctrl #(.EARLY_ZERO(1'b1)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p)
  );

  mul32_seq_ctrl #(.EARLY_ZERO(1'b0)) u_dut_nz (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .product   (product2),
    .busy      (busy2),
    .mul_a     (mul_a2),
    .mul_b     (mul_b2),
    .mul_p     (mul_p2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the main instance. With stall>0, out_ready is held low for
  // that many cycles after out_valid; if chain is set the next pair (na,nb) is presented
  // during the stall and left on the inputs for the following call to pick up.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int stall,
                        input bit chain, input logic [31:0] na, input logic [31:0] nb);
    logic [63:0] exp_p;
    logic [63:0] held;
    int          exp_lat;
    int          n;
    logic [7:0]  ea;
    logic [7:0]  eb;
    exp_p   = {32'h0, a} * {32'h0, b};
    exp_lat = (a == 32'd0 || b == 32'd0) ? 1 : 17;
    in_valid  = 1'b1;
    op_a      = a;
    op_b      = b;
    out_ready = (stall == 0);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    n = 1;
    while (!out_valid && n < 40) begin
      if (n <= 16) begin
        ea = a[8*((n-1)%4) +: 8];
        eb = b[8*((n-1)/4) +: 8];
        chk("core_bytes", {48'h0, mul_a, mul_b}, {48'h0, ea, eb});
        chk("busy_calc", 64'(busy), 64'd1);
      end
      tick();
      n++;
    end
    chk("latency", 64'(n), 64'(exp_lat));
    chk("product", product, exp_p);
    chk("in_ready_done", 64'(in_ready), 64'd0);
    chk("core_idle_done", {48'h0, mul_a, mul_b}, 64'd0);
    held = product;
    for (int s = 0; s < stall; s++) begin
      if (chain) begin
        in_valid = 1'b1;
        op_a     = na;
        op_b     = nb;
      end
      tick();
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_product", product, held);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("valid_dropped", 64'(out_valid), 64'd0);
    chk("in_ready_after", 64'(in_ready), 64'd1);
    chk("busy_after", 64'(busy), 64'd0);
  endtask

  initial begin
    int          seen;
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_valid2  = 1'b0;
    out_ready  = 1'b0;
    out_ready2 = 1'b0;
    op_a       = 32'd0;
    op_b       = 32'd0;
    repeat (3) tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_product", product, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_core", {48'h0, mul_a, mul_b}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Directed cases.
    run_op(32'd3, 32'd5, 0, 1'b0, 32'd0, 32'd0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 32'd0, 32'd0);
    run_op(32'h0001_0000, 32'h0001_0000, 0, 1'b0, 32'd0, 32'd0);
    run_op(32'd0, 32'h1234_5678, 0, 1'b0, 32'd0, 32'd0);

    // Backpressure, with a competing request that must wait for the handshake.
    run_op(32'h0BAD_F00D, 32'h0000_1234, 5, 1'b1, 32'h8765_4321, 32'h0000_00FF);
    run_op(32'h8765_4321, 32'h0000_00FF, 0, 1'b0, 32'd0, 32'd0);

    // Zero operand without the bypass takes the full schedule.
    op_a       = 32'd0;
    op_b       = 32'h1234_5678;
    in_valid2  = 1'b1;
    out_ready2 = 1'b1;
    chk("nz_in_ready", 64'(in_ready2), 64'd1);
    tick();
    in_valid2 = 1'b0;
    seen = 1;
    while (!out_valid2 && seen < 40) begin
      tick();
      seen++;
    end
    chk("nz_latency", 64'(seen), 64'd17);
    chk("nz_product", product2, 64'd0);
    chk("nz_busy", 64'(busy2), 64'd1);
    tick();
    chk("nz_valid_dropped", 64'(out_valid2), 64'd0);

    // Reset in the middle of CALC at step 7.
    in_valid  = 1'b1;
    op_a      = 32'hDEAD_BEEF;
    op_b      = 32'h0123_4567;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    chk("k7_core_bytes", {48'h0, mul_a, mul_b}, {48'h0, 8'hDE, 8'h45});
    rst_n = 1'b0;
    tick();
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_product", product, 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_core", {48'h0, mul_a, mul_b}, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (20) begin
      if (out_valid) seen++;
      tick();
    end
    chk("aborted_no_output", 64'(seen), 64'd0);
    run_op(32'h0000_0100, 32'h0000_0100, 0, 1'b0, 32'd0, 32'd0);

    // Randomized traffic with occasional zero operands and stalls.
    for (int t = 0; t < 24; t++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'd0;
      if ($urandom_range(0, 5) == 0) rb = 32'd0;
      if ($urandom_range(0, 3) == 0) ra = {24'd0, ra[7:0]};
      run_op(ra, rb, int'($urandom_range(0, 3)), 1'b0, 32'd0, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul32_seq_ctrl.md
# mul32_seq_ctrl

Sequencer that computes a 32x32 unsigned product by time-sharing one external 8x8 combinational multiplier core over 16 cycles. It accepts operand pairs on a valid/ready input port and schedules the 16 byte-pair partial products onto the shared core. It accumulates the shifted partial products into a 64-bit result and returns that result on a valid/ready output port. It sits between the 32-bit multiply requester and the 8x8 multiplier instance in the 32-bit multiply subsystem.

## Interface

Parameters:
- EARLY_ZERO, default 1: when 1, an operand pair with either operand equal to zero bypasses CALC and completes with product 0.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  reset, synchronous and active-low
- in_valid  input  1  operand pair present
- in_ready  output  1  block can accept an operand pair
- op_a  input  32  multiplicand, unsigned
- op_b  input  32  multiplier, unsigned
- out_valid  output  1  product is valid
- out_ready  input  1  consumer accepts the product
- product  output  64  unsigned product op_a*op_b
- busy  output  1  high in CALC or DONE
- mul_a  output  8  byte of op_a driven to the 8x8 core
- mul_b  output  8  byte of op_b driven to the 8x8 core
- mul_p  input  16  core product mul_a*mul_b, combinational in the same cycle

## Operation

- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, op_a and op_b are registered, the 64-bit accumulator is cleared and step counter k is set to 0.
  - Next state is CALC.
  - With EARLY_ZERO=1 and op_a==0 or op_b==0, the next state is DONE with the accumulator at 0.
- CALC (k = 0..15):
  - i=k[1:0] and j=k[3:2].
  - mul_a = A[8i+7:8i] and mul_b = B[8j+7:8j].
  - Each cycle: acc <= acc + ({48'h0, mul_p} << 8*(i+j)).
  - After k=15 the next state is DONE; otherwise k increments.
- DONE:
  - out_valid=1 and product=acc, both held stable until out_ready.
  - On out_ready the block returns to IDLE.
- Width rules:
  - The accumulator is 64 bits; the maximum sum, 0xFFFFFFFE00000001, cannot overflow.
  - No truncation of any partial product.
- mul_a and mul_b are 0 outside CALC, so the core is idle with no toggling.
- in_ready is 0 in CALC and DONE. in_valid in those states is ignored, and the requester must hold its operands.
- Registered operands are stable through CALC. Changes on op_a or op_b after acceptance have no effect.
- Reset (rst_n=0 at a clock edge, in any state including mid-CALC or DONE):
  - The state goes to IDLE.
  - k=0, acc=0, out_valid=0, product=0, busy=0, mul_a=0, mul_b=0.
  - in_ready=1 from the first edge after rst_n returns high.
  - Any in-flight operation is discarded with no output.

## Timing

- Acceptance edge T: state CALC from T+1, with steps k=0..15 on cycles T+1..T+16.
- out_valid rises at T+17, giving a latency of 17 cycles from acceptance to the first out_valid cycle.
- EARLY_ZERO bypass: out_valid rises at T+1.
- Output handshake completing at edge U: in_ready=1 during cycle U+1. The earliest next acceptance is edge U+1, so there is one bubble.
- Sustained throughput: one product per 18 cycles when out_ready is tied high.
- out_valid and product never change while out_valid=1 and out_ready=0.
- All outputs are registered, except:
  - in_ready and busy are decoded from the state register;
  - mul_a and mul_b are a combinational mux from the registered operands and k.

## Test plan

- 3 x 5, out_ready=1 -> product=64'h000000000000000F, out_valid on cycle T+17, exactly one cycle high.
- 0xFFFFFFFF x 0xFFFFFFFF -> product=64'hFFFFFFFE00000001.
- 0x00010000 x 0x00010000 -> product=64'h0000000100000000. Check the mul_a/mul_b sequence over the 16 cycles: nonzero (0x01, 0x01) only at k=10.
- 0 x 0x12345678 with EARLY_ZERO=1 -> product=0, out_valid at T+1. With EARLY_ZERO=0 -> product=0 at T+17.
- out_ready held low 5 cycles after out_valid -> product stable, in_ready=0, and a new in_valid with different operands is not accepted. That pair is accepted on the cycle after out_ready and produces its own correct product.
- rst_n low for one cycle at k=7 of an operation -> all outputs 0, in_ready=1 after release, no out_valid for the aborted pair. A following 0x00000100 x 0x00000100 yields 64'h0000000000010000.
